lbfgs_hist_seq: RTL

- Sequencer that drives one or more lock-stepped rho/s/y history ring memories for the L-BFGS two-loop recursion in the face-fit optimizer.
- Per iteration it:
  - writes the new pair;
  - issues N backward reads (newest to oldest);
  - waits for the middle H0 step;
  - issues N forward reads (oldest to newest).
- Memory data goes straight to the datapath. This block only produces the memory strobes and a valid/ready qualifier with phase and age tags.

---
 rtl/lbfgs_pkg.sv | 23 ++
 rtl/lbfgs_hist_seq_out_slot.sv | 54 +++++
 rtl/lbfgs_hist_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lbfgs_pkg.sv
// Shared types and constants for the L-BFGS history sequencer and its ring memories.
//   seq_state_t : sequencer states
//   phase_t     : two-loop recursion phase tag (backward / forward)
//   HIST_DEPTH_DEF : default history depth, shared with the memory instances
package lbfgs_pkg;

  localparam int unsigned HIST_DEPTH_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    BWD,
    MID,
    FWD,
    FIN
  } seq_state_t;

  typedef enum logic {
    PH_BWD = 1'b0,
    PH_FWD = 1'b1
  } phase_t;

endpackage

// File: rtl/lbfgs_hist_seq_out_slot.sv
// hist_out_slot: one-entry valid/ready register carrying the tags of the read
// currently presented to the datapath.
//   clk, rst      : clock, async active-low reset
//   clr           : synchronous flush (abort), highest priority
//   load          : a read is being issued this cycle; capture ld_* tags
//   ready         : datapath accepts the presented element
//   valid/phase/age/last : registered qualifier and tags
//   permit_c      : combinational; a new read may be issued this cycle
module hist_out_slot
  import lbfgs_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  phase_t        ld_phase,
  input  logic [CW-1:0] ld_age,
  input  logic          ld_last,
  input  logic          ready,
  output logic          valid,
  output phase_t        phase,
  output logic [CW-1:0] age,
  output logic          last,
  output logic          permit_c
);

  // Slot is free, or is being drained this cycle.
  assign permit_c = !valid || ready;

  // Load beats drain so a consumed element is replaced in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      phase <= PH_BWD;
      age   <= '0;
      last  <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
      phase <= PH_BWD;
      age   <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      phase <= ld_phase;
      age   <= ld_age;
      last  <= ld_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lbfgs_hist_seq.sv
// lbfgs_hist_seq: sequences the rho/s/y history ring memories through one
// L-BFGS two-loop iteration: optional pair write, N newest-to-oldest reads,
// wait for the H0 middle step, then N oldest-to-newest reads.
//   clk, rst          : clock, async active-low reset (also resets the memories)
//   start, new_pair   : begin iteration; write a new pair first when new_pair=1
//   abort             : synchronous abort back to IDLE
//   mid_done          : H0 middle step finished
//   out_ready         : datapath accepts the current read result
//   mem_wr_en/mem_rd_en/mem_loop_next : memory strobes (loop_next=1 on forward reads)
//   out_valid/out_phase/out_age/out_last : qualifier and tags for memory dout
//   mid_req, busy, done, err, hist_cnt   : status
module lbfgs_hist_seq
  import lbfgs_pkg::*;
#(
  parameter int unsigned HIST_DEPTH = HIST_DEPTH_DEF,
  localparam int unsigned CW = $clog2(HIST_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          new_pair,
  input  logic          abort,
  input  logic          mid_done,
  input  logic          out_ready,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic          mem_loop_next,
  output logic          out_valid,
  output logic          out_phase,
  output logic [CW-1:0] out_age,
  output logic          out_last,
  output logic          mid_req,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] hist_cnt
);

  seq_state_t    state, state_next;
  logic [CW-1:0] hist_cnt_next;
  logic [CW-1:0] n_lat, n_next;
  logic [CW-1:0] rd_idx, rd_idx_next;
  logic          err_next;

  logic          permit;
  logic          reads_left;
  logic          accept_last;
  phase_t        ld_phase;
  logic [CW-1:0] ld_age;
  logic          ld_last;
  phase_t        slot_phase;

  // rd_idx counts reads issued in the current phase; age is derived from it.
  assign reads_left = rd_idx < n_lat;
  assign ld_phase   = (state == FWD) ? PH_FWD : PH_BWD;
  assign ld_age     = (state == FWD) ? CW'(n_lat - rd_idx - CW'(1)) : rd_idx;
  assign ld_last    = rd_idx == CW'(n_lat - CW'(1));
  assign accept_last = out_valid && out_ready && out_last;
  assign out_phase  = slot_phase == PH_FWD;

  // State register and sequencer bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hist_cnt <= '0;
      n_lat    <= '0;
      rd_idx   <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      hist_cnt <= hist_cnt_next;
      n_lat    <= n_next;
      rd_idx   <= rd_idx_next;
      err      <= err_next;
    end
  end

  // Next-state and strobe decode; abort overrides everything at the end.
  always_comb begin
    state_next    = state;
    hist_cnt_next = hist_cnt;
    n_next        = n_lat;
    rd_idx_next   = rd_idx;
    err_next      = err;
    mem_wr_en     = 1'b0;
    mem_rd_en     = 1'b0;
    mem_loop_next = 1'b0;
    mid_req       = 1'b0;
    done          = 1'b0;
    busy          = state != IDLE;

    case (state)
      IDLE: begin
        if (start) begin
          if (new_pair) begin
            state_next = WRITE;
          end else begin
            // Without a fresh write the ring read pointers are stale.
            if (hist_cnt != '0) err_next = 1'b1;
            state_next = FIN;
          end
        end
      end
      WRITE: begin
        mem_wr_en     = 1'b1;
        hist_cnt_next = (hist_cnt == CW'(HIST_DEPTH)) ? hist_cnt : CW'(hist_cnt + CW'(1));
        n_next        = hist_cnt_next;
        rd_idx_next   = '0;
        state_next    = BWD;
      end
      BWD, FWD: begin
        mem_rd_en     = reads_left && permit;
        mem_loop_next = (state == FWD) && mem_rd_en;
        if (mem_rd_en) rd_idx_next = CW'(rd_idx + CW'(1));
        if (accept_last) begin
          rd_idx_next = '0;
          state_next  = (state == BWD) ? MID : FIN;
        end
      end
      MID: begin
        mid_req = 1'b1;
        if (mid_done) state_next = FWD;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (abort) begin
      state_next    = IDLE;
      hist_cnt_next = hist_cnt;
      n_next        = n_lat;
      rd_idx_next   = rd_idx;
      err_next      = err;
      mem_wr_en     = 1'b0;
      mem_rd_en     = 1'b0;
      mem_loop_next = 1'b0;
    end
  end

  hist_out_slot #(
    .CW(CW)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .load     (mem_rd_en),
    .ld_phase (ld_phase),
    .ld_age   (ld_age),
    .ld_last  (ld_last),
    .ready    (out_ready),
    .valid    (out_valid),
    .phase    (slot_phase),
    .age      (out_age),
    .last     (out_last),
    .permit_c (permit)
  );

endmodule
